// File: rtl/gshare_predictor.sv
// Gshare direction predictor: speculative global history XOR PC selects a
// saturating counter; a sweep after reset initialises the counter table.
module gshare_predictor #(
    parameter int XLEN      = 32,
    parameter int HIST_BITS = 10,
    parameter int CTR_BITS  = 2,
    parameter int PC_LSB    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_req,
    input  logic [XLEN-1:0]      pred_pc,
    input  logic                 pred_is_branch,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    output logic                 ready,
    input  logic                 upd_valid,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 dbg_state
);

    localparam int DEPTH = 1 << HIST_BITS;

    localparam logic [HIST_BITS-1:0] SWEEP_ONE  = HIST_BITS'(1);
    localparam logic [HIST_BITS-1:0] SWEEP_LAST = '1;
    localparam logic [CTR_BITS-1:0]  CTR_ONE    = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0]  CTR_ZERO   = '0;
    localparam logic [CTR_BITS-1:0]  CTR_MAX    = '1;
    // Weakly not-taken: just below the taken threshold (0 for 1-bit counters).
    localparam logic [CTR_BITS-1:0]  CTR_INIT   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Handshake: a fetch slot is consumed whenever pred_req is high; there is
    // no back-pressure. ready is a level status, low only while the table
    // sweep runs; predictions are forced not-taken and commits ignored then.

    state_t                 state_q, state_d;
    logic [HIST_BITS-1:0]   sweep_q, sweep_d;
    logic                   ready_q, ready_d;
    logic [HIST_BITS-1:0]   spec_hist_q, spec_hist_d;

    logic [CTR_BITS-1:0]    ctr_mem [DEPTH];

    logic [HIST_BITS-1:0]   idx_rd;
    logic [HIST_BITS-1:0]   idx_wr;
    logic [CTR_BITS-1:0]    rd_ctr;
    logic [CTR_BITS-1:0]    upd_ctr_cur;
    logic [CTR_BITS-1:0]    upd_ctr_next;

    logic                   tbl_we;
    logic [HIST_BITS-1:0]   tbl_waddr;
    logic [CTR_BITS-1:0]    tbl_wdata;

    logic                   unused_pc_bits;

    assign idx_rd = spec_hist_q ^ pred_pc[PC_LSB +: HIST_BITS];
    assign idx_wr = upd_hist ^ upd_pc[PC_LSB +: HIST_BITS];

    assign rd_ctr      = ctr_mem[idx_rd];
    assign upd_ctr_cur = ctr_mem[idx_wr];

    assign pred_taken = ready_q & rd_ctr[CTR_BITS-1];
    assign pred_hist  = spec_hist_q;
    assign ready      = ready_q;
    assign dbg_state  = (state_q == ST_RUN);

    // Only the index slice of each PC matters.
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready_d = ready_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + SWEEP_ONE;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // A committed mispredict flushes the fetch slot, so repair wins over the shift.
    always_comb begin
        spec_hist_d = spec_hist_q;
        if (ready_q) begin
            if (upd_valid && upd_mispredict) begin
                spec_hist_d = {upd_hist[HIST_BITS-2:0], upd_taken};
            end else if (pred_req && pred_is_branch) begin
                spec_hist_d = {spec_hist_q[HIST_BITS-2:0], pred_taken};
            end
        end
    end

    always_comb begin
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken) begin
            if (upd_ctr_cur != CTR_MAX) begin
                upd_ctr_next = upd_ctr_cur + CTR_ONE;
            end
        end else begin
            if (upd_ctr_cur != CTR_ZERO) begin
                upd_ctr_next = upd_ctr_cur - CTR_ONE;
            end
        end
    end

    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = sweep_q;
        tbl_wdata = CTR_INIT;
        if (state_q == ST_INIT) begin
            tbl_we = 1'b1;
        end else if (upd_valid) begin
            tbl_we    = 1'b1;
            tbl_waddr = idx_wr;
            tbl_wdata = upd_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            ready_q     <= 1'b0;
            spec_hist_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ready_q     <= ready_d;
            spec_hist_q <= spec_hist_d;
        end
    end

    // The table has no reset; the sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            ctr_mem[tbl_waddr] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor against a behavioural table model.
module tb_gshare_predictor;

    localparam int XLEN      = 32;
    localparam int HIST_BITS = 10;
    localparam int CTR_BITS  = 2;
    localparam int PC_LSB    = 2;
    localparam int DEPTH     = 1 << HIST_BITS;
    localparam int CTR_MAX   = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF  = 1 << (CTR_BITS - 1);

    logic                 clk;
    logic                 reset;
    logic                 pred_req;
    logic [XLEN-1:0]      pred_pc;
    logic                 pred_is_branch;
    logic                 pred_taken;
    logic [HIST_BITS-1:0] pred_hist;
    logic                 ready;
    logic                 upd_valid;
    logic [XLEN-1:0]      upd_pc;
    logic [HIST_BITS-1:0] upd_hist;
    logic                 upd_taken;
    logic                 upd_mispredict;
    logic                 dbg_state;

    int checks = 0;
    int errors = 0;

    int m_ctr [DEPTH];
    int m_hist;
    bit m_ready;
    int m_sweep;

    logic [0:0] exp_q[$];

    gshare_predictor #(
        .XLEN(XLEN), .HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS), .PC_LSB(PC_LSB)
    ) dut (
        .clk(clk), .reset(reset),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_is_branch(pred_is_branch),
        .pred_taken(pred_taken), .pred_hist(pred_hist), .ready(ready),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int m_idx(input logic [XLEN-1:0] pc, input int hist);
        return (hist ^ int'(pc >> PC_LSB)) % DEPTH;
    endfunction

    function automatic bit m_pred(input logic [XLEN-1:0] pc);
        if (!m_ready) return 1'b0;
        return m_ctr[m_idx(pc, m_hist)] >= CTR_HALF;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_sweep = 0;
        m_hist  = 0;
    endtask

    task automatic model_clock();
        bit pt;
        int wi;
        if (!m_ready) begin
            m_ctr[m_sweep] = CTR_HALF - 1;
            m_sweep++;
            if (m_sweep == DEPTH) m_ready = 1'b1;
        end else begin
            pt = m_pred(pred_pc);
            wi = m_idx(upd_pc, int'(upd_hist));
            if (upd_valid && upd_mispredict)
                m_hist = (int'(upd_hist) * 2 + int'(upd_taken)) % DEPTH;
            else if (pred_req && pred_is_branch)
                m_hist = (m_hist * 2 + int'(pt)) % DEPTH;
            if (upd_valid) begin
                if (upd_taken) m_ctr[wi] = (m_ctr[wi] < CTR_MAX) ? m_ctr[wi] + 1 : CTR_MAX;
                else           m_ctr[wi] = (m_ctr[wi] > 0) ? m_ctr[wi] - 1 : 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pred_req       = 1'b0;
        pred_pc        = '0;
        pred_is_branch = 1'b0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_hist       = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Runs the init sweep to completion; returns cycles with ready low.
    task automatic run_init(input bit init_traffic, output int zeros, output int bad);
        zeros = 0;
        bad   = 0;
        for (int i = 0; i < 2000 && ready !== 1'b1; i++) begin
            pred_req       = 1'b1;
            pred_pc        = $urandom;
            pred_is_branch = 1'($urandom_range(0, 1));
            if (init_traffic) begin
                upd_valid      = 1'b1;
                upd_pc         = 32'h100;
                upd_hist       = '0;
                upd_taken      = 1'b1;
                upd_mispredict = 1'b1;
            end
            #1;
            if (pred_taken !== 1'b0) bad++;
            if (pred_hist !== '0) bad++;
            zeros++;
            cycle();
        end
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        pred_req       = 1'b1;
        pred_is_branch = 1'b1;
        pred_pc        = 32'h100;
        reset          = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken);
        end
        checks++;
        if (pred_hist !== '0) begin
            errors++; $display("FAIL reset_pred_hist: got %h expected 0", pred_hist);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", ready);
        end
        repeat (3) @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_init_timing();
        int zeros, bad;
        run_init(1'b0, zeros, bad);
        checks++;
        if (zeros != DEPTH) begin
            errors++; $display("FAIL init_ready_len: got %0d cycles expected %0d", zeros, DEPTH);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL init_outputs_quiet: got %0d bad samples expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            pred_req = 1'b1;
            pred_pc  = $urandom;
            #1;
            if (pred_taken !== 1'b0 || pred_taken !== m_pred(pred_pc)) bad++;
            cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL init_all_weak_nt: got %0d taken predictions expected 0", bad);
        end
    endtask

    task automatic test_training_saturation();
        logic [0:0] e;
        idle_inputs();
        pred_req = 1'b1;
        pred_pc  = 32'h100;
        upd_pc   = 32'h100;
        upd_hist = '0;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL train_initial: got %b expected 0", pred_taken);
        end
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            upd_valid = 1'b1;
            upd_taken = (i < 3);
            cycle();
            upd_valid = 1'b0;
            #1;
            e = exp_q.pop_front();
            checks++;
            if (pred_taken !== e[0] || pred_taken !== m_pred(pred_pc)) begin
                errors++;
                $display("FAIL train_step%0d: got %b expected %b", i, pred_taken, e[0]);
            end
        end
    endtask

    task automatic test_spec_shift();
        idle_inputs();
        pred_req = 1'b1;
        pred_pc  = 32'h100;
        upd_pc   = 32'h100;
        upd_hist = '0;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1;
            upd_taken = 1'b1;
            cycle();
        end
        upd_valid      = 1'b0;
        pred_is_branch = 1'b1;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_hist !== 10'h000) begin
            errors++;
            $display("FAIL shift_predict: got taken=%b hist=%h expected taken=1 hist=000",
                     pred_taken, pred_hist);
        end
        cycle();
        pred_is_branch = 1'b0;
        #1;
        checks++;
        if (pred_hist !== 10'h001 || pred_hist !== m_hist[HIST_BITS-1:0]) begin
            errors++; $display("FAIL shift_advance: got %h expected 001", pred_hist);
        end
        cycle();
        checks++;
        if (pred_hist !== 10'h001) begin
            errors++; $display("FAIL shift_nonbranch_hold: got %h expected 001", pred_hist);
        end
        pred_req       = 1'b0;
        pred_is_branch = 1'b1;
        cycle();
        checks++;
        if (pred_hist !== 10'h001) begin
            errors++; $display("FAIL shift_noreq_hold: got %h expected 001", pred_hist);
        end
        idle_inputs();
    endtask

    task automatic test_repair_priority();
        idle_inputs();
        pred_req       = 1'b1;
        pred_is_branch = 1'b1;
        pred_pc        = $urandom;
        upd_valid      = 1'b1;
        upd_mispredict = 1'b1;
        upd_hist       = 10'h2AA;
        upd_taken      = 1'b1;
        upd_pc         = 32'h100;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (pred_hist !== 10'h155 || pred_hist !== m_hist[HIST_BITS-1:0]) begin
            errors++; $display("FAIL repair_priority: got %h expected 155", pred_hist);
        end
    endtask

    task automatic test_same_index();
        idle_inputs();
        pred_req  = 1'b1;
        pred_pc   = 32'h0;
        upd_pc    = 32'h0;
        upd_hist  = 10'h155;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL same_idx_old_value: got %b expected 0", pred_taken);
        end
        cycle();
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL same_idx_new_value: got %b expected 1", pred_taken);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int bad_t, bad_h;
        bad_t = 0;
        bad_h = 0;
        for (int i = 0; i < 400; i++) begin
            pred_req       = ($urandom_range(0, 3) != 0);
            pred_pc        = $urandom;
            pred_is_branch = 1'($urandom_range(0, 1));
            upd_valid      = 1'($urandom_range(0, 1));
            upd_taken      = 1'($urandom_range(0, 1));
            upd_mispredict = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                upd_pc   = pred_pc;
                upd_hist = m_hist[HIST_BITS-1:0];
            end else begin
                upd_pc   = 32'($urandom_range(0, 255)) << PC_LSB;
                upd_hist = HIST_BITS'($urandom_range(0, DEPTH - 1));
            end
            #1;
            if (pred_taken !== m_pred(pred_pc)) begin
                bad_t++;
                if (bad_t < 4)
                    $display("FAIL random_pred_taken: cycle %0d got %b expected %b",
                             i, pred_taken, m_pred(pred_pc));
            end
            if (pred_hist !== m_hist[HIST_BITS-1:0]) begin
                bad_h++;
                if (bad_h < 4)
                    $display("FAIL random_pred_hist: cycle %0d got %h expected %h",
                             i, pred_hist, m_hist[HIST_BITS-1:0]);
            end
            cycle();
        end
        idle_inputs();
        checks++;
        if (bad_t != 0) errors++;
        checks++;
        if (bad_h != 0) errors++;
    endtask

    task automatic test_mid_init_reset();
        int zeros, bad;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            upd_valid      = 1'b1;
            upd_pc         = 32'h100;
            upd_hist       = '0;
            upd_taken      = 1'b1;
            upd_mispredict = 1'b1;
            cycle();
        end
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready !== 1'b0 || pred_hist !== '0) begin
            errors++;
            $display("FAIL midinit_reset_state: got ready=%b hist=%h expected 0/000", ready, pred_hist);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_init(1'b1, zeros, bad);
        checks++;
        if (zeros != DEPTH) begin
            errors++; $display("FAIL midinit_ready_len: got %0d cycles expected %0d", zeros, DEPTH);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midinit_outputs_quiet: got %0d bad samples expected 0", bad);
        end
        pred_req = 1'b1;
        pred_pc  = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_hist !== '0) begin
            errors++;
            $display("FAIL midinit_no_training: got taken=%b hist=%h expected 0/000", pred_taken, pred_hist);
        end
        upd_valid = 1'b1;
        upd_pc    = 32'h100;
        upd_hist  = '0;
        upd_taken = 1'b1;
        cycle();
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL midinit_weak_nt_entry: got %b expected 1", pred_taken);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            pred_pc = $urandom;
            #1;
            if (pred_taken !== m_pred(pred_pc)) bad++;
            cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midinit_table_reinit: got %0d wrong predictions expected 0", bad);
        end
        idle_inputs();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = -1;
        test_reset();
        test_init_timing();
        test_training_saturation();
        test_spec_shift();
        test_repair_priority();
        test_same_index();
        test_random();
        test_mid_init_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
